pll_lock_monitor: RTL and testbench

PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

---
 rtl/pll_lock_monitor.sv | 120 ++++++++++++
 tb/tb_pll_lock_monitor.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_monitor.sv
// PLL lock qualifier: synchronizes LOCKED, qualifies stability, pulses PLL reset on timeout.
// Optional loss-of-lock event counter enabled by LOCK_LOSS_CNT_EN.
module pll_lock_monitor #(
  parameter int unsigned STABLE_CYCLES  = 256,
  parameter int unsigned LOCK_TIMEOUT   = 4096,
  parameter int unsigned PLL_RST_CYCLES = 16
) (
  input  logic       LS_CLK,
  input  logic       RST,
  input  logic       lock,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       ready,
`ifdef LOCK_LOSS_CNT_EN
  output logic [2:0] state,
  output logic [7:0] loss_cnt
`else
  output logic [2:0] state
`endif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    LOST      = 3'd4,
    PLL_RST   = 3'd5
  } state_t;

  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] RST_LAST = 16'(PLL_RST_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sync1, lock_s;

  always_ff @(posedge LS_CLK) begin
    if (RST) begin
      sync1   <= 1'b0;
      lock_s  <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      sync1   <= lock;
      lock_s  <= sync1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = PLL_RST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RUN: begin
        if (!lock_s) state_d = LOST;
      end
      LOST: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
      PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign pll_rst  = (state_q == PLL_RST);
  assign ready    = (state_q == RUN);
  assign core_rst = !(state_q == RUN);
  assign state    = state_q;

`ifdef LOCK_LOSS_CNT_EN
  // LOST is only ever entered from RUN on a dropped lock_s
  always_ff @(posedge LS_CLK) begin
    if (RST) begin
      loss_cnt <= '0;
    end else if (state_q == RUN && !lock_s && loss_cnt != 8'hff) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Randomized and directed checks of pll_lock_monitor against a cycle model.
// Loss counter checks are active when LOCK_LOSS_CNT_EN is defined.
module tb_pll_lock_monitor;

  localparam int SC = 8;
  localparam int TO = 32;
  localparam int PR = 4;

  logic       LS_CLK = 1'b0;
  logic       RST = 1'b1;
  logic       lock = 1'b0;
  logic       pll_rst, core_rst, ready;
  logic [2:0] state;
`ifdef LOCK_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  pll_lock_monitor #(
    .STABLE_CYCLES (SC),
    .LOCK_TIMEOUT  (TO),
    .PLL_RST_CYCLES(PR)
  ) dut (
    .LS_CLK  (LS_CLK),
    .RST     (RST),
    .lock    (lock),
    .pll_rst (pll_rst),
    .core_rst(core_rst),
    .ready   (ready),
`ifdef LOCK_LOSS_CNT_EN
    .state   (state),
    .loss_cnt(loss_cnt)
`else
    .state   (state)
`endif
  );

  always #5 LS_CLK = ~LS_CLK;

  int n_checks = 0;
  int n_errors = 0;

  int m_state, m_cnt, m_loss;
  bit lq[$];

  wire [5:0] obs = {pll_rst, core_rst, ready, state};

  function automatic logic [5:0] exp_vec();
    return {(m_state == 5), (m_state != 3), (m_state == 3), 3'(m_state)};
  endfunction

  task automatic model_step();
    bit ls;
    if (RST) begin
      m_state = 0; m_cnt = 0; m_loss = 0;
      lq.delete(); lq.push_back(1'b0); lq.push_back(1'b0);
    end else begin
      ls = lq.pop_front();
      lq.push_back(lock);
      case (m_state)
        0: begin m_state = 1; m_cnt = 0; end
        1: if (ls) begin m_state = 2; m_cnt = 0; end
           else if (m_cnt == TO - 1) begin m_state = 5; m_cnt = 0; end
           else m_cnt++;
        2: if (!ls) begin m_state = 1; m_cnt = 0; end
           else if (m_cnt == SC - 1) m_state = 3;
           else m_cnt++;
        3: if (!ls) begin
             m_state = 4;
             if (m_loss < 255) m_loss++;
           end
        4: begin m_state = 1; m_cnt = 0; end
        5: if (m_cnt == PR - 1) begin m_state = 1; m_cnt = 0; end
           else m_cnt++;
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge LS_CLK);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; lock = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (obs !== 6'b010000) begin
      n_errors++;
      $display("FAIL reset_outputs got=%b want=010000", obs);
    end
`ifdef LOCK_LOSS_CNT_EN
    n_checks++;
    if (loss_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_loss got=%0d want=0", loss_cnt);
    end
`endif
  endtask

  task automatic test_startup();
    RST = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      tick();
      n_checks++;
      if (ready !== (i >= 11) || core_rst !== (i < 11)) begin
        n_errors++;
        $display("FAIL startup edge=%0d ready=%b core_rst=%b want_ready=%b",
                 i, ready, core_rst, (i >= 11));
      end
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++;
        $display("FAIL startup_model edge=%0d got=%b want=%b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_timeout();
    logic want;
    RST = 1'b1; lock = 1'b0;
    repeat (2) tick();
    RST = 1'b0;
    for (int i = 1; i <= 150; i++) begin
      tick();
      want = ((i - 1) % (TO + PR)) >= TO;
      n_checks++;
      if (pll_rst !== want || ready !== 1'b0) begin
        n_errors++;
        $display("FAIL timeout cyc=%0d pll_rst=%b ready=%b want_pll_rst=%b",
                 i, pll_rst, ready, want);
      end
    end
  endtask

  task automatic test_loss();
    int lost_n, after_lost, seen;
    bit ok;
    RST = 1'b1; lock = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin tick(); ok = ready; end
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL loss_initial_ready timeout"); end
`ifdef LOCK_LOSS_CNT_EN
    n_checks++;
    if (loss_cnt !== 8'd0) begin
      n_errors++; $display("FAIL loss_cnt_before got=%0d want=0", loss_cnt);
    end
`endif
    lock = 1'b0;
    lost_n = 0; after_lost = -1; seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) lock = 1'b1;
      tick();
      if (seen == 1 && after_lost < 0) after_lost = state;
      if (state == 3'd4) begin
        lost_n++; seen = 1;
        n_checks++;
        if (ready !== 1'b0 || core_rst !== 1'b1) begin
          n_errors++;
          $display("FAIL loss_outputs ready=%b core_rst=%b", ready, core_rst);
        end
      end
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++;
        $display("FAIL loss_model cyc=%0d got=%b want=%b", i, obs, exp_vec());
      end
    end
    n_checks++;
    if (lost_n != 1 || after_lost != 1) begin
      n_errors++;
      $display("FAIL loss_sequence lost_cycles=%0d next=%0d want 1 and 1",
               lost_n, after_lost);
    end
`ifdef LOCK_LOSS_CNT_EN
    n_checks++;
    if (loss_cnt !== 8'd1) begin
      n_errors++; $display("FAIL loss_cnt_after got=%0d want=1", loss_cnt);
    end
`endif
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin tick(); ok = ready; end
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL loss_requalify timeout"); end
  endtask

  task automatic test_glitch_stable();
    int waits, stables;
    bit ok, in_wait_seen;
    RST = 1'b1; lock = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick(); ok = (m_state == 2 && m_cnt == 3);
    end
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL glitch_reach_stable timeout"); end
    lock = 1'b0;
    tick();
    lock = 1'b1;
    waits = 0; stables = 0; in_wait_seen = 0; ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (state == 3'd1) begin waits++; in_wait_seen = 1; end
      else if (state == 3'd2 && in_wait_seen) stables++;
      else if (state == 3'd3) ok = 1;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++;
        $display("FAIL glitch_model cyc=%0d got=%b want=%b", i, obs, exp_vec());
      end
    end
    n_checks++;
    if (!ok || waits != 1 || stables != SC) begin
      n_errors++;
      $display("FAIL glitch_requal run=%0b waits=%0d stables=%0d want 1,1,%0d",
               ok, waits, stables, SC);
    end
  endtask

`ifdef LOCK_LOSS_CNT_EN
  task automatic test_loss_saturate();
    bit ok;
    RST = 1'b1; lock = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin tick(); ok = ready; end
    for (int n = 0; n < 300; n++) begin
      lock = 1'b0;
      tick();
      lock = 1'b1;
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin tick(); ok = ready; end
      if (!ok) begin
        n_checks++; n_errors++;
        $display("FAIL sat_requal timeout event=%0d", n);
        break;
      end
    end
    n_checks++;
    if (loss_cnt !== 8'd255 || m_loss != 255) begin
      n_errors++;
      $display("FAIL sat_value got=%0d model=%0d want=255", loss_cnt, m_loss);
    end
    RST = 1'b1;
    tick();
    n_checks++;
    if (loss_cnt !== 8'd0) begin
      n_errors++; $display("FAIL sat_clear got=%0d want=0", loss_cnt);
    end
  endtask
`endif

  task automatic test_reset_mid_pll_rst();
    bit ok;
    RST = 1'b1; lock = 1'b0;
    repeat (2) tick();
    RST = 1'b0;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin tick(); ok = (state == 3'd5); end
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL midrst_reach timeout"); end
    tick();
    n_checks++;
    if (pll_rst !== 1'b1) begin
      n_errors++; $display("FAIL midrst_second_cycle pll_rst=%b want=1", pll_rst);
    end
    RST = 1'b1;
    tick();
    n_checks++;
    if (pll_rst !== 1'b0 || state !== 3'd0) begin
      n_errors++;
      $display("FAIL midrst_abort pll_rst=%b state=%0d want 0,0", pll_rst, state);
    end
    RST = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_checks++;
      if (pll_rst !== 1'b0) begin
        n_errors++; $display("FAIL midrst_residual cyc=%0d pll_rst=%b", i, pll_rst);
      end
    end
  endtask

  task automatic test_random();
    int run;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    run = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        lock = $urandom_range(0, 3) != 0;
        run = lock ? $urandom_range(1, 60) : $urandom_range(1, 8);
        if ($urandom_range(0, 9) == 0) run = $urandom_range(30, 45);
      end
      run--;
      RST = ($urandom_range(0, 299) == 0);
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++;
        $display("FAIL random cyc=%0d got=%b want=%b", i, obs, exp_vec());
      end
`ifdef LOCK_LOSS_CNT_EN
      n_checks++;
      if (loss_cnt !== 8'(m_loss)) begin
        n_errors++;
        $display("FAIL random_loss cyc=%0d got=%0d want=%0d", i, loss_cnt, m_loss);
      end
`endif
    end
    RST = 1'b0;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_timeout();
    test_loss();
    test_glitch_stable();
`ifdef LOCK_LOSS_CNT_EN
    test_loss_saturate();
`endif
    test_reset_mid_pll_rst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
